// File: rtl/hist_pkg.sv
// Shared definitions for the histogramming datapath: default sizes, the bin
// index type and the sample-to-bin reduction used by ingress and increment.
package hist_pkg;

    localparam int DATA_W     = 8;
    localparam int BIN_W      = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

    typedef logic [BIN_W-1:0]   bin_t;
    typedef logic [LEVEL_W-1:0] level_t;

    // A bin is the top BIN_W bits of the sample.
    function automatic bin_t sample_to_bin(input logic [DATA_W-1:0] sample);
        return sample[DATA_W-1 -: BIN_W];
    endfunction

endpackage

// File: rtl/hist_sample_ingress_if.sv
// Bin stream from the ingress block to the bin-increment stage (valid/ready).
interface hist_sample_ingress_if;
    import hist_pkg::*;

    bin_t bin_out;
    logic bin_valid;
    logic bin_ready;

    modport master (
        output bin_out,
        output bin_valid,
        input  bin_ready
    );

    modport slave (
        input  bin_out,
        input  bin_valid,
        output bin_ready
    );

endinterface

// File: rtl/hist_bin_fifo.sv
// Synchronous FIFO with a registered show-ahead head. The head register is
// refreshed from storage one cycle after an entry lands, so an entry written
// into an empty FIFO becomes visible on the following cycle (no pass-through).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hist_bin_fifo #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic [LW-1:0]    level_w;
    logic             do_push, do_pop;
    logic [AW-1:0]    rd_idx, rd_idx_nxt;

    assign level_w    = wr_ptr_q - rd_ptr_q;
    assign full       = (level_w == LW'(DEPTH));
    assign do_pop     = pop & head_valid_q;
    assign do_push    = push & (~full | do_pop);
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign rd_idx_nxt = rd_idx + AW'(1);

    assign head       = head_q;
    assign head_valid = head_valid_q;
    assign level      = level_w;

    // Next-state for storage, pointers and the registered head.
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
        wr_ptr_d     = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d     = rd_ptr_q + (AW+1)'(do_pop);
        // Head reads storage as it was before this cycle's write.
        head_d       = do_pop ? mem_q[rd_idx_nxt] : mem_q[rd_idx];
        head_valid_d = ((level_w - LW'(do_pop)) != '0);
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

endmodule

// File: rtl/hist_sample_ingress.sv
// Histogram ingress: synchronises the asynchronous sample strobe, detects its
// rising edge, reduces the aligned sample to a bin index and buffers it for
// the bin-increment stage. Drops on a full FIFO set a sticky overflow flag.
// Optional build macro HIST_INGRESS_OVF_CNT_EN adds a saturating 8-bit count
// of dropped samples; without it ovf_count is constant zero.
module hist_sample_ingress
    import hist_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  strobe_in,
    hist_sample_ingress_if.master bin_if,
    output level_t                fifo_level,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic [7:0]            ovf_count
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    bin_t                   samp_q [SYNC_STAGES];
    bin_t                   samp_d [SYNC_STAGES];
    logic                   edge_q, edge_d;
    logic                   overflow_q, overflow_d;

    logic push_req;
    logic pop;
    logic fifo_full;
    logic drop;
    bin_t head_bin;
    logic head_valid;

    // Strobe synchroniser and bin pipeline of matching depth, so the bin at
    // the end of the pipeline belongs to the edge being detected.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], strobe_in};
        samp_d[0] = sample_to_bin(sample_in);
        for (int i = 1; i < SYNC_STAGES; i++) begin
            samp_d[i] = samp_q[i-1];
        end
        edge_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser, bin pipeline and edge registers. The edge register resets
    // low, so a strobe already high when reset releases yields one push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                samp_q[i] <= '0;
            end
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            samp_q <= samp_d;
            edge_q <= edge_d;
        end
    end

    // Edges seen while disabled are discarded, not held for later.
    assign push_req = sync_q[SYNC_STAGES-1] & ~edge_q & ena;
    assign pop      = head_valid & bin_if.bin_ready;
    assign drop     = push_req & fifo_full & ~pop;

    hist_bin_fifo #(
        .WIDTH (BIN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_req),
        .push_data  (samp_q[SYNC_STAGES-1]),
        .pop        (pop),
        .head       (head_bin),
        .head_valid (head_valid),
        .full       (fifo_full),
        .level      (fifo_level)
    );

    assign bin_if.bin_out   = head_bin;
    assign bin_if.bin_valid = head_valid;

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef HIST_INGRESS_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating drop counter; clear together with a drop loads one.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_ovf) begin
            ovf_cnt_d = 8'd0;
        end
        if (drop) begin
            if (clear_ovf) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'd0;
`endif

endmodule
